// File: rtl/seg_decode.sv
// seg_decode: snapshots four 7-segment patterns and streams their hex decodes
// out one digit per handshake, then publishes the assembled word and error mask.
module seg_decode #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [27:0] seg,
  output logic        busy,
  output logic        valid,
  input  logic        ready,
  output logic [1:0]  dig,
  output logic [3:0]  val,
  output logic        err,
  output logic        done,
  output logic [15:0] word,
  output logic [3:0]  bad
);
  localparam logic S_IDLE = 1'b0;
  localparam logic S_OUT  = 1'b1;

  logic             state_q, state_d;
  logic [3:0][6:0]  snap_q, snap_d;
  logic             valid_q, valid_d;
  logic [1:0]       dig_q, dig_d;
  logic [3:0]       val_q, val_d;
  logic             err_q, err_d;
  logic [2:0][3:0]  acc_q, acc_d;
  logic [2:0]       accb_q, accb_d;
  logic [15:0]      word_q, word_d;
  logic [3:0]       bad_q, bad_d;
  logic             done_q, done_d;

  // returns {err, val}; unknown glyphs decode to 0 with err set
  function automatic logic [4:0] dec(input logic [6:0] s);
    logic [6:0] p;
    p = ACTIVE_LOW ? s : ~s;
    case (p)
      7'h40: return 5'h00;
      7'h79: return 5'h01;
      7'h24: return 5'h02;
      7'h30: return 5'h03;
      7'h19: return 5'h04;
      7'h12: return 5'h05;
      7'h02: return 5'h06;
      7'h78: return 5'h07;
      7'h00: return 5'h08;
      7'h10: return 5'h09;
      7'h08: return 5'h0A;
      7'h03: return 5'h0B;
      7'h46: return 5'h0C;
      7'h21: return 5'h0D;
      7'h06: return 5'h0E;
      7'h0E: return 5'h0F;
      default: return 5'h10;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    snap_d = snap_q;
    valid_d = valid_q;
    dig_d = dig_q;
    val_d = val_q;
    err_d = err_q;
    acc_d = acc_q;
    accb_d = accb_q;
    word_d = word_q;
    bad_d = bad_q;
    done_d = 1'b0;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_OUT;
        snap_d = seg;
        valid_d = 1'b1;
        dig_d = 2'd0;
        {err_d, val_d} = dec(seg[6:0]);
      end
    end else if (valid_q && ready) begin
      if (dig_q == 2'd3) begin
        state_d = S_IDLE;
        valid_d = 1'b0;
        done_d = 1'b1;
        word_d = {val_q, acc_q[2], acc_q[1], acc_q[0]};
        bad_d = {err_q, accb_q};
      end else begin
        acc_d[dig_q] = val_q;
        accb_d[dig_q] = err_q;
        dig_d = dig_q + 2'd1;
        {err_d, val_d} = dec(snap_q[dig_q + 2'd1]);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      snap_q <= '0;
      valid_q <= 1'b0;
      dig_q <= 2'd0;
      val_q <= 4'd0;
      err_q <= 1'b0;
      acc_q <= '0;
      accb_q <= '0;
      word_q <= '0;
      bad_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q <= snap_d;
      valid_q <= valid_d;
      dig_q <= dig_d;
      val_q <= val_d;
      err_q <= err_d;
      acc_q <= acc_d;
      accb_q <= accb_d;
      word_q <= word_d;
      bad_q <= bad_d;
      done_q <= done_d;
    end
  end

  assign busy = state_q;
  assign valid = valid_q;
  assign dig = dig_q;
  assign val = val_q;
  assign err = err_q;
  assign done = done_q;
  assign word = word_q;
  assign bad = bad_q;
endmodule

// File: tb/tb_seg_decode.sv
// tb_seg_decode: runs an active-low and an active-high instance side by side on
// complementary patterns and checks both against a table-lookup reference.
module tb_seg_decode;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        ready = 1'b0;
  logic [27:0] seg = '0;
  logic [27:0] seg_n;
  logic        busy, valid, err, done, busy_n, valid_n, err_n, done_n;
  logic [1:0]  dig, dig_n;
  logic [3:0]  val, bad, val_n, bad_n;
  logic [15:0] word, word_n;
  logic [29:0] o1, o0;
  logic [15:0] word_exp = '0;
  logic [3:0]  bad_exp = '0;
  int          n_cmp = 0;
  int          n_bad = 0;

  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  assign seg_n = ~seg;
  assign o1 = {busy, valid, valid ? {dig, val, err} : 7'b0, done, word, bad};
  assign o0 = {busy_n, valid_n, valid_n ? {dig_n, val_n, err_n} : 7'b0, done_n, word_n, bad_n};

  seg_decode #(.ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst(rst), .start(start), .seg(seg), .busy(busy), .valid(valid), .ready(ready),
    .dig(dig), .val(val), .err(err), .done(done), .word(word), .bad(bad));

  seg_decode #(.ACTIVE_LOW(1'b0)) dut_n (
    .clk(clk), .rst(rst), .start(start), .seg(seg_n), .busy(busy_n), .valid(valid_n), .ready(ready),
    .dig(dig_n), .val(val_n), .err(err_n), .done(done_n), .word(word_n), .bad(bad_n));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_dec(input logic [6:0] p);
    for (int i = 0; i < 16; i++)
      if (GLYPH[i] == p) return {1'b0, 4'(i)};
    return 5'h10;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_st(input string tag, input logic b, input logic v, input logic [1:0] d,
                        input logic [4:0] ve, input logic dn);
    logic [29:0] e;
    e = {b, v, v ? {d, ve[3:0], ve[4]} : 7'b0, dn, word_exp, bad_exp};
    chk({tag, "/al1"}, 32'(o1), 32'(e));
    chk({tag, "/al0"}, 32'(o0), 32'(e));
  endtask

  function automatic logic [6:0] rand_pat();
    return ($urandom_range(0, 4) != 0) ? GLYPH[$urandom_range(0, 15)] : 7'($urandom);
  endfunction

  // stall_dig gets exactly three stall cycles; other digits get 0..max_stall
  task automatic scan(input logic [27:0] s, input int max_stall, input int stall_dig);
    logic [4:0] r [4];
    int n;
    for (int d = 0; d < 4; d++) r[d] = ref_dec(s[7*d +: 7]);
    seg = s;
    start = 1'b1;
    ready = 1'b0;
    tick();
    start = 1'b0;
    for (int d = 0; d < 4; d++) begin
      exp_st($sformatf("present%0d", d), 1'b1, 1'b1, 2'(d), r[d], 1'b0);
      n = (d == stall_dig) ? 3 : $urandom_range(0, max_stall);
      for (int k = 0; k < n; k++) begin
        ready = 1'b0;
        seg = 28'($urandom);
        start = 1'($urandom_range(0, 1));
        tick();
        start = 1'b0;
        exp_st($sformatf("stall%0d", d), 1'b1, 1'b1, 2'(d), r[d], 1'b0);
      end
      ready = 1'b1;
      if (d == 3) begin
        word_exp = {r[3][3:0], r[2][3:0], r[1][3:0], r[0][3:0]};
        bad_exp = {r[3][4], r[2][4], r[1][4], r[0][4]};
      end
      tick();
      ready = 1'b0;
    end
    exp_st("done", 1'b0, 1'b0, 2'd0, 5'd0, 1'b1);
  endtask

  initial begin
    tick();
    tick();
    exp_st("reset", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    chk("reset_raw", {dig, val, err, dig_n, val_n, err_n}, 32'd0);
    rst = 1'b0;
    scan({7'h21, 7'h46, 7'h03, 7'h08}, 0, -1);
    chk("abcd_word", word, 32'hDCBA);
    chk("abcd_bad", bad, 32'h0);
    scan({7'h30, 7'h24, 7'h7F, 7'h40}, 0, -1);
    chk("blank_word", word, 32'h3200);
    chk("blank_bad", bad, 32'h2);
    scan({rand_pat(), rand_pat(), rand_pat(), rand_pat()}, 0, 2);
    scan({7'h79, 7'h40, 7'h0E, 7'h00}, 0, -1);
    chk("al0_word", word_n, 32'h10F8);
    chk("al0_bad", bad_n, 32'h0);
    tick();
    exp_st("idle", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    // abort at digit 2 with an asynchronous reset between clock edges
    seg = {rand_pat(), rand_pat(), rand_pat(), rand_pat()};
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b1;
    tick();
    tick();
    chk("pre_rst_dig", dig, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    word_exp = '0;
    bad_exp = '0;
    exp_st("async_rst", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    chk("async_rst_raw", {dig, val, err, dig_n, val_n, err_n}, 32'd0);
    start = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    start = 1'b0;
    ready = 1'b0;
    tick();
    exp_st("post_rst", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
    for (int i = 0; i < 30; i++) begin
      scan({rand_pat(), rand_pat(), rand_pat(), rand_pat()}, 2, -1);
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        tick();
        exp_st("gap", 1'b0, 1'b0, 2'd0, 5'd0, 1'b0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
